mundo_match_seq: RTL

//  Registered, parametrised unlock-code detector for the level/"mundo" select logic.
//  - Compares a W-bit switch word against NPAT constant patterns while op is low.
//  - Asserts a sticky set only after one pattern has matched for HOLD consecutive clocks.
//  - Reports which pattern won; set stays high until cleared.
//  - Feeds the 7-seg/level control path in place of purely combinational matchers.

---
 rtl/mundo_pkg.sv | 25 ++
 rtl/mundo_match_seq_if.sv | 38 +++
 rtl/pattern_cmp.sv | 30 +++
 rtl/mundo_match_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mundo_pkg.sv
// ---------------------------------------------------------------------------
// mundo_pkg
// Shared types and constants for the mundo unlock-code detector.
//   mundo_st_t        : detector FSM states (IDLE, ARM, LOCKED)
//   ENC_IDLE/ARM/LOCK : legacy 2-bit encodings of those states
//   idxWidth()        : width of a pattern index for n patterns (min 1)
// ---------------------------------------------------------------------------
package mundo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_LOCKED = 2'd2
   } mundo_st_t;

   localparam logic [1:0] ENC_IDLE   = ST_IDLE;
   localparam logic [1:0] ENC_ARM    = ST_ARM;
   localparam logic [1:0] ENC_LOCKED = ST_LOCKED;

   // A single pattern still needs a one-bit index so ports never collapse to zero width
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mundo_match_seq_if.sv
// ---------------------------------------------------------------------------
// mundo_match_seq_if
// Bundles the switch-word inputs and the detector status outputs.
//   op       : 1 = operation mode (matching disabled)
//   data     : W-bit switch word
//   clr      : synchronous clear of lock/arm state
//   set      : sticky "code accepted"
//   hit_idx  : accepted / candidate pattern index
//   hit_pls  : one-cycle pulse on lock
//   arming   : high while a candidate is being held
// Modports: master drives op/data/clr, slave (the detector) drives the status.
// ---------------------------------------------------------------------------
interface mundo_match_seq_if
   import mundo_pkg::*;
#(
   parameter int W  = 18,
   parameter int IW = idxWidth(2)
);

   logic          op;
   logic [W-1:0]  data;
   logic          clr;
   logic          set;
   logic [IW-1:0] hit_idx;
   logic          hit_pls;
   logic          arming;

   modport master (
      output op, data, clr,
      input  set, hit_idx, hit_pls, arming
   );

   modport slave (
      input  op, data, clr,
      output set, hit_idx, hit_pls, arming
   );

endinterface

// File: rtl/pattern_cmp.sv
// ---------------------------------------------------------------------------
// pattern_cmp
// Compares one data word against one constant pattern.
//   data : word under test (W bits)
//   pat  : pattern (W bits)
//   mask : care mask, 1 = compare this bit (W bits)
//   eq   : 1 when data matches pat
// Build option MATCH_MASK_EN: when defined, masked-out bits are don't-care;
// otherwise the compare is exact and the mask is expected tied to all ones.
// ---------------------------------------------------------------------------
module pattern_cmp
   import mundo_pkg::*;
#(
   parameter int W = 18
)(
   input  logic [W-1:0] data,
   input  logic [W-1:0] pat,
   input  logic [W-1:0] mask,
   output logic         eq
);

`ifdef MATCH_MASK_EN
   // Only bits with a 1 in the mask take part in the compare
   assign eq = (((data ^ pat) & mask) == '0);
`else
   // Exact compare; the mask is tied to all ones so the AND reduces to a constant
   assign eq = (data == pat) && (&mask);
`endif

endmodule

// File: rtl/mundo_match_seq.sv
// ---------------------------------------------------------------------------
// mundo_match_seq
// Registered unlock-code detector: a pattern must match for HOLD consecutive
// clocks (with op low) before the sticky 'set' output rises.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mundo_match_seq_if.slave (op, data, clr in; set, hit_idx,
//           hit_pls, arming out)
// Parameters: W, NPAT, HOLD, PATS (pattern k = PATS[k*W +: W]), MASKS.
// Build option MATCH_MASK_EN: enables per-pattern don't-care masks (MASKS);
// without it the compare is exact and MASKS is ignored.
// ---------------------------------------------------------------------------
module mundo_match_seq
   import mundo_pkg::*;
#(
   parameter int               W     = 18,
   parameter int               NPAT  = 2,
   parameter int               HOLD  = 4,
   parameter logic [NPAT*W-1:0] PATS  = {18'h3FFFF, 18'h29820},
   parameter logic [NPAT*W-1:0] MASKS = {NPAT*W{1'b1}}
)(
   input logic             clk,
   input logic             rst_n,
   mundo_match_seq_if.slave bus
);

   localparam int IW = idxWidth(NPAT);
   localparam int CW = $clog2(HOLD + 1);

   logic [NPAT*W-1:0] maskVec;
   logic [NPAT-1:0]   eqVec;
   logic [NPAT-1:0]   matchVec;
   logic              anyMatch;
   logic [IW-1:0]     candIdx;
   logic              holdMatch;

   logic [1:0]        state_q,   state_d;
   logic [CW-1:0]     holdCnt_q, holdCnt_d;
   logic              set_q,     set_d;
   logic [IW-1:0]     hitIdx_q,  hitIdx_d;
   logic              hitPls_q,  hitPls_d;
   logic              arming_q,  arming_d;

`ifdef MATCH_MASK_EN
   assign maskVec = MASKS;
`else
   // OR with all ones keeps every mask bit set whatever MASKS holds
   assign maskVec = MASKS | {NPAT*W{1'b1}};
`endif

   // One comparator per pattern
   for (genvar k = 0; k < NPAT; k++) begin : g_cmp
      pattern_cmp #(.W(W)) u_cmp (
         .data (bus.data),
         .pat  (PATS[k*W +: W]),
         .mask (maskVec[k*W +: W]),
         .eq   (eqVec[k])
      );
   end

   assign matchVec = {NPAT{~bus.op}} & eqVec;
   assign anyMatch = |matchVec;

   // Fixed-priority encoder: scanning downwards lets the lowest index win.
   // Also looks up whether the pattern currently being held still matches.
   always_comb begin
      candIdx   = '0;
      holdMatch = 1'b0;
      for (int k = NPAT - 1; k >= 0; k--) begin
         if (matchVec[k]) begin
            candIdx = IW'(k);
         end
      end
      for (int k = 0; k < NPAT; k++) begin
         if (hitIdx_q == IW'(k)) begin
            holdMatch = matchVec[k];
         end
      end
   end

   // Next-state logic for the IDLE/ARM/LOCKED detector; clr overrides everything
   always_comb begin
      state_d   = state_q;
      holdCnt_d = holdCnt_q;
      set_d     = set_q;
      hitIdx_d  = hitIdx_q;
      hitPls_d  = 1'b0;
      if (bus.clr) begin
         state_d   = ENC_IDLE;
         holdCnt_d = '0;
         set_d     = 1'b0;
      end else begin
         case (state_q)
            ENC_IDLE: begin
               if (anyMatch) begin
                  hitIdx_d = candIdx;
                  if (HOLD == 1) begin
                     state_d  = ENC_LOCKED;
                     set_d    = 1'b1;
                     hitPls_d = 1'b1;
                  end else begin
                     state_d   = ENC_ARM;
                     holdCnt_d = CW'(1);
                  end
               end
            end
            ENC_ARM: begin
               if (holdMatch) begin
                  if (holdCnt_q == CW'(HOLD - 1)) begin
                     state_d   = ENC_LOCKED;
                     holdCnt_d = '0;
                     set_d     = 1'b1;
                     hitPls_d  = 1'b1;
                  end else begin
                     holdCnt_d = holdCnt_q + CW'(1);
                  end
               end else if (anyMatch) begin
                  holdCnt_d = CW'(1);
                  hitIdx_d  = candIdx;
               end else begin
                  state_d   = ENC_IDLE;
                  holdCnt_d = '0;
               end
            end
            ENC_LOCKED: begin
               state_d = ENC_LOCKED;
            end
            default: begin
               state_d   = ENC_IDLE;
               holdCnt_d = '0;
               set_d     = 1'b0;
            end
         endcase
      end
      arming_d = (state_d == ENC_ARM);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ENC_IDLE;
         holdCnt_q <= '0;
         set_q     <= 1'b0;
         hitIdx_q  <= '0;
         hitPls_q  <= 1'b0;
         arming_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
         set_q     <= set_d;
         hitIdx_q  <= hitIdx_d;
         hitPls_q  <= hitPls_d;
         arming_q  <= arming_d;
      end
   end

   assign bus.set     = set_q;
   assign bus.hit_idx = hitIdx_q;
   assign bus.hit_pls = hitPls_q;
   assign bus.arming  = arming_q;

endmodule
